// File: rtl/mips_bus_arb_pkg.sv
// Shared types and constants for the MIPS two-master bus arbiter.
// Exports the FSM state enum and the master index constants.
package mips_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic M_FETCH = 1'b0;
  localparam logic M_DATA  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; on a tie the master not served last wins.
// Ports: req0/req1 requests, last = last served, gnt = pick, valid = any.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    gnt   = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Serialises fetch (m0) and load/store (m1) onto one Avalon-style bus.
// Ports: m0/m1 master sides, downstream bus, waitrequest/readdata, busy.
module mips_bus_arbiter
  import mips_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;
  logic   arb_gnt, arb_valid;

  rr_arb2 u_rr (
    .req0  (m0_read),
    .req1  (m1_read | m1_write),
    .last  (last_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_gnt;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!waitrequest) begin
          state_d = ACK;
          last_d  = grant_q;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= M_FETCH;
      last_q  <= M_DATA;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Strobes exist only in GRANT; the bus is zero elsewhere.
  // A simultaneous m1 read+write is issued as a write.
  always_comb begin
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;
    if (state_q == GRANT) begin
      if (grant_q == M_DATA) begin
        address    = m1_address;
        write      = m1_write;
        read       = m1_read & ~m1_write;
        writedata  = m1_writedata;
        byteenable = m1_byteenable;
      end else begin
        address    = m0_address;
        read       = 1'b1;
        byteenable = {BE_W{1'b1}};
      end
    end
  end

  always_comb begin
    busy           = (state_q != IDLE);
    m0_waitrequest = !((state_q == ACK) && (grant_q == M_FETCH));
    m1_waitrequest = !((state_q == ACK) && (grant_q == M_DATA));
    m0_readdata    = (grant_q == M_FETCH) ? readdata : '0;
    m1_readdata    = (grant_q == M_DATA) ? readdata : '0;
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter.
// Hand-computed expectations checked with immediate assertions.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address;
  logic        m0_read;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;
  logic [31:0] m1_address;
  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_writedata;
  logic [3:0]  m1_byteenable;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_waitrequest (m0_waitrequest),
    .m0_readdata    (m0_readdata),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_byteenable  (m1_byteenable),
    .m1_waitrequest (m1_waitrequest),
    .m1_readdata    (m1_readdata),
    .address        (address),
    .read           (read),
    .write          (write),
    .writedata      (writedata),
    .byteenable     (byteenable),
    .waitrequest    (waitrequest),
    .readdata       (readdata),
    .busy           (busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_read  = 1'b0;
    m1_read  = 1'b0;
    m1_write = 1'b0;
  endtask

  int n0;
  int n1;

  initial begin
    reset         = 1'b1;
    m0_address    = '0;
    m0_read       = 1'b0;
    m1_address    = '0;
    m1_read       = 1'b0;
    m1_write      = 1'b0;
    m1_writedata  = '0;
    m1_byteenable = '0;
    waitrequest   = 1'b0;
    readdata      = '0;
    tick();
    tick();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_m0_wr", m0_waitrequest, 1);
    chk("rst_m1_wr", m1_waitrequest, 1);
    chk("rst_rd", read, 0);
    chk("rst_wr", write, 0);
    chk("rst_addr", address, 0);
    chk("rst_be", byteenable, 0);
    reset = 1'b0;

    // Lone fetch
    tick();
    m0_address = 32'hBFC0_0000;
    m0_read    = 1'b1;
    readdata   = 32'h3C08_BFC0;
    #1;
    chk("lf_c0_busy", busy, 0);
    chk("lf_c0_rd", read, 0);
    tick();
    chk("lf_c1_rd", read, 1);
    chk("lf_c1_wr", write, 0);
    chk("lf_c1_addr", address, 32'hBFC0_0000);
    chk("lf_c1_be", byteenable, 4'hF);
    chk("lf_c1_m0w", m0_waitrequest, 1);
    chk("lf_c1_busy", busy, 1);
    tick();
    chk("lf_c2_m0w", m0_waitrequest, 0);
    chk("lf_c2_m0d", m0_readdata, 32'h3C08_BFC0);
    chk("lf_c2_m1w", m1_waitrequest, 1);
    chk("lf_c2_rd", read, 0);
    idle_inputs();
    tick();
    chk("lf_c3_m0w", m0_waitrequest, 1);
    chk("lf_c3_busy", busy, 0);

    // Contention straight after reset: fetch wins first
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    m0_address = 32'h0000_00A0;
    m1_address = 32'h0000_00A1;
    m0_read    = 1'b1;
    m1_read    = 1'b1;
    readdata   = 32'h1234_5678;
    tick();
    chk("ct_c1_addr", address, 32'hA0);
    chk("ct_c1_rd", read, 1);
    tick();
    chk("ct_c2_m0w", m0_waitrequest, 0);
    chk("ct_c2_m1w", m1_waitrequest, 1);
    chk("ct_c2_m1d", m1_readdata, 0);
    m0_read = 1'b0;
    tick();
    chk("ct_c3_busy", busy, 0);
    tick();
    chk("ct_c4_addr", address, 32'hA1);
    chk("ct_c4_rd", read, 1);
    chk("ct_c4_be", byteenable, 0);
    tick();
    chk("ct_c5_m1w", m1_waitrequest, 0);
    chk("ct_c5_m0w", m0_waitrequest, 1);
    chk("ct_c5_m1d", m1_readdata, 32'h1234_5678);
    chk("ct_c5_m0d", m0_readdata, 0);
    idle_inputs();
    tick();

    // Stalled write
    m1_address    = 32'hBFC0_0030;
    m1_writedata  = 32'h0000_000F;
    m1_byteenable = 4'hF;
    m1_write      = 1'b1;
    waitrequest   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) waitrequest = 1'b0;
      #1;
      chk("sw_wr", write, 1);
      chk("sw_rd", read, 0);
      chk("sw_addr", address, 32'hBFC0_0030);
      chk("sw_data", writedata, 32'h0000_000F);
      chk("sw_be", byteenable, 4'hF);
      chk("sw_m1w", m1_waitrequest, 1);
    end
    tick();
    chk("sw_c5_m1w", m1_waitrequest, 0);
    chk("sw_c5_wr", write, 0);
    idle_inputs();
    tick();
    chk("sw_c6_m1w", m1_waitrequest, 1);

    // m1 read and write together: write wins
    m1_address    = 32'h0000_0040;
    m1_byteenable = 4'h3;
    m1_read       = 1'b1;
    m1_write      = 1'b1;
    tick();
    chk("rw_c1_wr", write, 1);
    chk("rw_c1_rd", read, 0);
    chk("rw_c1_be", byteenable, 4'h3);
    tick();
    chk("rw_c2_m1w", m1_waitrequest, 0);
    idle_inputs();
    tick();
    chk("rw_c3_m1w", m1_waitrequest, 1);
    chk("rw_c3_busy", busy, 0);

    // Reset in the middle of a stalled GRANT
    m0_address  = 32'h0000_0100;
    m0_read     = 1'b1;
    waitrequest = 1'b1;
    tick();
    chk("rg_c1_rd", read, 1);
    reset = 1'b1;
    tick();
    chk("rg_c2_rd", read, 0);
    chk("rg_c2_wr", write, 0);
    chk("rg_c2_m0w", m0_waitrequest, 1);
    chk("rg_c2_m1w", m1_waitrequest, 1);
    chk("rg_c2_busy", busy, 0);
    reset       = 1'b0;
    m0_read     = 1'b0;
    waitrequest = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rg_post_m0w", m0_waitrequest, 1);
      chk("rg_post_m1w", m1_waitrequest, 1);
      chk("rg_post_busy", busy, 0);
    end

    // Continuous requests from both: alternate m0, m1
    m0_address = 32'h0000_0200;
    m1_address = 32'h0000_0300;
    m0_read    = 1'b1;
    m1_read    = 1'b1;
    readdata   = 32'hCAFE_F00D;
    n0 = 0;
    n1 = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("cc_m0w", m0_waitrequest, (c == 2 || c == 8) ? 1'b0 : 1'b1);
      chk("cc_m1w", m1_waitrequest, (c == 5 || c == 11) ? 1'b0 : 1'b1);
      if (!m0_waitrequest) begin
        n0++;
        chk("cc_m0d", m0_readdata, 32'hCAFE_F00D);
      end
      if (!m1_waitrequest) n1++;
    end
    chk("cc_n0", n0, 2);
    chk("cc_n1", n1, 2);
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master arbiter sharing the single Avalon-style memory bus of the MIPS CPU between the instruction-fetch port (master 0) and the load/store port (master 1). It sits between the CPU's internal fetch/data units and the external bus (`address`, `read`, `write`, `writedata`, `byteenable`, `waitrequest`, `readdata`). It serialises one transaction at a time, grants round-robin on contention, and returns completion and read data to the granted master.

## Interface
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, data width; `byteenable` is `DATA_W/8` bits
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `m0_address` in ADDR_W: fetch request address
- `m0_read` in 1: fetch read request
- `m0_waitrequest` out 1: low for exactly one cycle to complete an m0 transaction
- `m0_readdata` out DATA_W: valid while `m0_waitrequest`=0
- `m1_address` in ADDR_W: data request address
- `m1_read`, `m1_write` in 1: data read/write request
- `m1_writedata` in DATA_W; `m1_byteenable` in DATA_W/8
- `m1_waitrequest` out 1; `m1_readdata` out DATA_W: as for m0
- `address` out ADDR_W; `read`, `write` out 1; `writedata` out DATA_W; `byteenable` out DATA_W/8: downstream bus
- `waitrequest` in 1: downstream stall; a strobe is accepted in a cycle where it is high and `waitrequest`=0
- `readdata` in DATA_W: downstream data, valid the cycle after read acceptance (fixed latency 1)
- `busy` out 1: high in any state other than IDLE

## Operation
- States: IDLE, GRANT, ACK. Registers: `state`, `grant` (0/1), `last` (last master served).
- IDLE: `req0 = m0_read`, `req1 = m1_read | m1_write`. If one request is present, grant it. If both are present, grant `!last`. Go to GRANT. With no requests, stay in IDLE.
- GRANT: drive the downstream bus combinationally from the granted master's inputs. m0 drives `write`=0, `writedata`=0, `byteenable`=4'b1111. On acceptance (`waitrequest`=0), go to ACK and set `last <= grant`. Otherwise hold GRANT with the strobe asserted.
- ACK: downstream `read`/`write` = 0. Forward `readdata` to the granted master's readdata and drive that master's waitrequest low. Next state: IDLE.
- `mK_waitrequest` = 0 only in ACK with `grant`=K. It is 1 in every other state, including reset.
- `mK_readdata` = `readdata` when `grant`=K, else 0. It carries meaningful data only in ACK after a read.
- If `m1_read` and `m1_write` are both high, the write wins and `read` stays 0. The master still completes normally.
- Masters hold their request stable until they see waitrequest low. The arbiter does not latch request fields.
- A request dropped before completion is a protocol violation. The behaviour is undefined; no check is required.

## Timing
- Reset values: `state`=IDLE, `grant`=0, `last`=1 (fetch wins the first tie), `read`=`write`=0, `address`=`writedata`=0, `byteenable`=0, both waitrequests=1, `busy`=0.
- Minimum latency: request seen in IDLE at cycle N, strobe on bus at N+1, master completion at N+2.
- Each extra cycle of downstream `waitrequest` adds one cycle in GRANT.
- Throughput: one transaction every 3 cycles with no stalls. ACK always returns to IDLE, so the next arbitration happens in IDLE.
- Fairness: under continuous requests from both masters, grants alternate 0,1,0,1.
- `reset` asserted in any state takes effect at the next edge. An in-flight downstream strobe is dropped and no completion is issued to any master.
- `reset` has priority over all transitions.

## Structure
- Package `mips_bus_arb_pkg`: `state_t` enum {IDLE, GRANT, ACK}, constants `M_FETCH`=0 and `M_DATA`=1.
- Sub-module `rr_arb2`: combinational two-way round-robin picker with inputs (`req0`, `req1`, `last`) and outputs (`gnt`, `valid`).
- The top holds the FSM, registers, and datapath muxes.

## Test plan
- Lone fetch: `m0_read`=1, `m0_address`=0xBFC00000, memory returns 0x3C08BFC0 with no stall. Expected: `read`=1 at cycle 1, `m0_waitrequest`=0 with `m0_readdata`=0x3C08BFC0 at cycle 2, `m1_waitrequest`=1 throughout.
- Contention after reset: both masters request in cycle 0. Expected: m0 is served first (completes at cycle 2), then m1 (`address`=m1's address at cycle 4, completes at cycle 5).
- Stalled write: `m1_write`=1, `m1_address`=0xBFC00030, data 0x0000000F, byteenable 4'b1111, downstream `waitrequest` high for 3 cycles. Expected: `write` held for 4 cycles with stable fields, then `m1_waitrequest`=0 exactly one cycle later.
- Read and write asserted together on m1. Expected: `write`=1, `read`=0 on the bus; a single completion.
- Reset mid-GRANT, with `waitrequest` held high. Expected: the next cycle shows `read`=`write`=0, both waitrequests=1, `busy`=0; no completion pulse appears afterwards.
- Continuous requests from both masters for 12 cycles with no stalls. Expected: 4 completions in order m0, m1, m0, m1, each 3 cycles apart.
